instr_fetch_unit: RTL

//  Fetch stage upstream of the multi-cycle datapath. Owns the PC, issues word reads to

---
 rtl/risc24_pkg.sv | 13 +
 rtl/instr_fetch_unit_if.sv | 26 ++
 rtl/fetch_timeout_ctr.sv | 29 ++
 rtl/instr_fetch_unit.sv | 125 ++++++++++++
 4 files changed

// File: rtl/risc24_pkg.sv
// Shared definitions for the risc24 core: datapath width, reset PC and fetch FSM encodings.
package risc24_pkg;

    localparam int unsigned XLEN = 16;
    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 16'h0000;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StReq  = 2'd1,
        StHold = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Fetch-stage bus: instruction-memory read handshake plus the IR valid/ready hand-off.
interface instr_fetch_unit_if;
    import risc24_pkg::*;

    logic            mem_req;
    logic [XLEN-1:0] mem_addr;
    logic [XLEN-1:0] mem_rdata;
    logic            mem_ack;
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] instr_pc;
    logic            instr_valid;
    logic            instr_ready;

    // Fetch unit side.
    modport master (
        output mem_req, mem_addr, instr, instr_pc, instr_valid,
        input  mem_rdata, mem_ack, instr_ready
    );

    // Memory and decode side.
    modport slave (
        input  mem_req, mem_addr, instr, instr_pc, instr_valid,
        output mem_rdata, mem_ack, instr_ready
    );

endinterface

// File: rtl/fetch_timeout_ctr.sv
// Counts cycles spent waiting for an instruction-memory ack; flags expiry at TIMEOUT cycles.
module fetch_timeout_ctr #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic count,
    output logic expired
);

    localparam int unsigned CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] cnt_q;

    // Expiry fires on the TIMEOUT-th counted cycle, not one after.
    assign expired = count && (cnt_q == CW'(TIMEOUT - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (clear) begin
            cnt_q <= '0;
        end else if (count && !expired) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, reads instruction memory over req/ack and hands the IR to decode.
// Optional fetch timeout enabled by defining FETCH_TIMEOUT_EN.
module instr_fetch_unit
    import risc24_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT,
    parameter logic [XLEN-1:0] PC_STEP  = 16'd1
`ifdef FETCH_TIMEOUT_EN
    ,
    parameter int unsigned     TIMEOUT  = 16
`endif
) (
    input  logic                clk,
    input  logic                reset,
    instr_fetch_unit_if.master  bus,
    input  logic                redirect,
    input  logic [XLEN-1:0]     redirect_pc,
    output logic [1:0]          state,
    output logic                fetch_err
);

    fetch_state_e    state_q;
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] addr_q;
    logic [XLEN-1:0] instr_q;
    logic [XLEN-1:0] instr_pc_q;
    logic            valid_q;
    logic            kill_q;
    logic            err_q;
    logic            timeout_hit;
    logic [XLEN-1:0] pc_inc;

    assign pc_inc = pc_q + PC_STEP;

`ifdef FETCH_TIMEOUT_EN
    fetch_timeout_ctr #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk     (clk),
        .reset   (reset),
        .clear   ((state_q != StReq) || bus.mem_ack),
        .count   ((state_q == StReq) && !bus.mem_ack),
        .expired (timeout_hit)
    );
`else
    assign timeout_hit = 1'b0;
`endif

    // addr_q holds the in-flight request address; pc_q may move under it on a redirect.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= StIdle;
            pc_q       <= RESET_PC;
            addr_q     <= RESET_PC;
            instr_q    <= '0;
            instr_pc_q <= '0;
            valid_q    <= 1'b0;
            kill_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (redirect) begin
                        pc_q   <= redirect_pc;
                        addr_q <= redirect_pc;
                    end else begin
                        addr_q <= pc_q;
                    end
                    if (!err_q) state_q <= StReq;
                end
                StReq: begin
                    if (timeout_hit) begin
                        err_q   <= 1'b1;
                        kill_q  <= 1'b0;
                        state_q <= StIdle;
                        if (redirect) pc_q <= redirect_pc;
                    end else if (redirect) begin
                        pc_q    <= redirect_pc;
                        valid_q <= 1'b0;
                        // An outstanding request must still complete; its data is discarded.
                        kill_q  <= !bus.mem_ack;
                        if (bus.mem_ack) addr_q <= redirect_pc;
                    end else if (bus.mem_ack) begin
                        if (kill_q) begin
                            kill_q <= 1'b0;
                            addr_q <= pc_q;
                        end else begin
                            instr_q    <= bus.mem_rdata;
                            instr_pc_q <= pc_q;
                            valid_q    <= 1'b1;
                            state_q    <= StHold;
                        end
                    end
                end
                StHold: begin
                    if (redirect) begin
                        pc_q    <= redirect_pc;
                        addr_q  <= redirect_pc;
                        valid_q <= 1'b0;
                        state_q <= StReq;
                    end else if (bus.instr_ready) begin
                        pc_q    <= pc_inc;
                        addr_q  <= pc_inc;
                        valid_q <= 1'b0;
                        state_q <= StReq;
                    end
                end
                default: begin
                    state_q <= StIdle;
                    valid_q <= 1'b0;
                    kill_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.mem_req     = (state_q == StReq);
    assign bus.mem_addr    = addr_q;
    assign bus.instr       = instr_q;
    assign bus.instr_pc    = instr_pc_q;
    assign bus.instr_valid = valid_q;
    assign state           = state_q;
    assign fetch_err       = err_q;

endmodule
